ones_cnt_sched: RTL

Round-robin scheduler that shares one serial ones counter (ports clk, reset, data, count[0:3]) among NREQ requesters. It accepts a WIDTH-bit word from one requester and clears the counter. It then shifts the word into the counter one bit per cycle, captures the resulting 4-bit count, and returns it tagged with the requester id. It sits between the requester agents and the single counter instance and is the only driver of that counter's reset and data inputs.

---
 rtl/ones_cnt_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/ones_cnt_sched.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ones_cnt_pkg.sv
// Shared types and constants for the ones-counter scheduler.
// The result width is fixed by the external 4-bit serial counter.
package ones_cnt_pkg;
  localparam int CNT_W     = 4;
  localparam int MAX_WIDTH = 15;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    CAPTURE,
    RESP
  } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr wins. The pointer register lives in the caller.
module rr_arbiter #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);
  logic [IDX_W:0]   idx_sum;
  logic [IDX_W-1:0] idx;

  // NOTE: every output and temporary gets a default before the loop, so no
  // path through the block leaves a variable unassigned and infers a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx_sum   = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (idx_sum >= (IDX_W+1)'(NREQ)) idx_sum = idx_sum - (IDX_W+1)'(NREQ);
      idx = idx_sum[IDX_W-1:0];
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/ones_cnt_sched.sv
// Round-robin scheduler sharing one serial ones counter among NREQ requesters:
// accept a word, clear the counter, shift the word in, return the tagged count.
module ones_cnt_sched
  import ones_cnt_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  cnt_reset,
  output logic                  cnt_data,
  input  logic [0:CNT_W-1]      cnt_count,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDX_W-1:0]      rsp_id,
  output logic [CNT_W-1:0]      rsp_count
);
  localparam int BIT_W = $clog2(MAX_WIDTH + 1);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("ones_cnt_sched: WIDTH must be in 1..%0d", MAX_WIDTH);
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("ones_cnt_sched: NREQ must be in 2..8");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]   rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]   rsp_count_q, rsp_count_d;

  logic [NREQ-1:0]    grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               grant_en;
  logic [WIDTH-1:0]   word_sel;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign word_sel = req_data[int'(grant_idx)*WIDTH +: WIDTH];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    rsp_id_d    = rsp_id_q;
    rsp_count_d = rsp_count_q;
    cnt_data    = 1'b0;
    grant_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_any && !reset) begin
          grant_en = 1'b1;
          shift_d  = word_sel;
          rsp_id_d = grant_idx;
          ptr_d    = (grant_idx == IDX_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        cnt_data  = shift_q[0];
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_W'(WIDTH-1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        // cnt_count is declared [0:3], so a plain copy keeps index 0 as the MSB.
        rsp_count_d = cnt_count;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      rsp_id_q    <= '0;
      rsp_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rsp_id_q    <= rsp_id_d;
      rsp_count_q <= rsp_count_d;
    end
  end

  assign req_ready = grant_en ? grant : '0;
  assign cnt_reset = reset || (state_q == CLEAR);
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_count = rsp_count_q;
endmodule
